// File: rtl/mfp_ahb_copy_master.sv
// mfp_ahb_copy_master
//   AHB-lite initiator that copies a block of 32-bit words from src_addr to
//   dst_addr using single NONSEQ transfers (read word, then write word).
//   Optional fill mode (compiled in with `define MFP_AHB_COPY_FILL_EN) skips
//   the reads and writes fill_data to every destination word.
//
// Ports
//   HCLK, HRESETn          bus clock, async active-low reset
//   start                  one-cycle request, sampled only in IDLE
//   src_addr, dst_addr     first byte addresses (bits [1:0] ignored)
//   len                    word count (0 = no transfer, done only)
//   fill, fill_data        fill-mode select/pattern (ignored without the macro)
//   busy, done, err        status: in progress / completion pulse / sticky error
//   H*                     AHB-lite master signals
module mfp_ahb_copy_master #(
    parameter int LEN_W = 16
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    input  logic             fill,
    input  logic [31:0]      fill_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      HADDR,
    output logic [2:0]       HBURST,
    output logic             HMASTLOCK,
    output logic [3:0]       HPROT,
    output logic [2:0]       HSIZE,
    output logic [1:0]       HTRANS,
    output logic [31:0]      HWDATA,
    output logic             HWRITE,
    input  logic [31:0]      HRDATA,
    input  logic             HREADY,
    input  logic             HRESP
);

    typedef enum logic [2:0] {S_IDLE, S_RA, S_RD, S_WA, S_WD, S_FIN} state_t;

    state_t           state_q, state_d;
    // Word addresses: the 30-bit increment wraps exactly like the byte address.
    logic [29:0]      src_q, src_d;
    logic [29:0]      dst_q, dst_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [31:0]      data_q, data_d;
    logic             err_q, err_d;
    // Remembers a len=0 request so busy covers its lone FIN cycle.
    logic             zlen_q, zlen_d;

    logic             fill_in;    // fill request as seen at start
    logic             fill_mode;  // fill mode of the running job
    logic [31:0]      wdata_fill;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{src_addr[1:0], dst_addr[1:0]};

`ifdef MFP_AHB_COPY_FILL_EN
    logic        fill_q, fill_d;
    logic [31:0] fdata_q, fdata_d;

    always_comb begin
        fill_d  = fill_q;
        fdata_d = fdata_q;
        if (state_q == S_IDLE && start) begin
            fill_d  = fill;
            fdata_d = fill_data;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            fill_q  <= 1'b0;
            fdata_q <= '0;
        end else begin
            fill_q  <= fill_d;
            fdata_q <= fdata_d;
        end
    end

    assign fill_in    = fill;
    assign fill_mode  = fill_q;
    assign wdata_fill = fdata_q;
`else
    logic unused_fill;
    assign unused_fill = ^{fill, fill_data};
    assign fill_in     = 1'b0;
    assign fill_mode   = 1'b0;
    assign wdata_fill  = '0;
`endif

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        zlen_d  = zlen_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d  = src_addr[31:2];
                    dst_d  = dst_addr[31:2];
                    cnt_d  = len;
                    err_d  = 1'b0;
                    zlen_d = (len == '0);
                    if (len == '0)   state_d = S_FIN;
                    else if (fill_in) state_d = S_WA;
                    else              state_d = S_RA;
                end
            end
            S_RA: if (HREADY) state_d = S_RD;
            S_RD: begin
                if (HREADY) begin
                    if (HRESP) begin
                        err_d   = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        data_d  = HRDATA;
                        state_d = S_WA;
                    end
                end
            end
            S_WA: if (HREADY) state_d = S_WD;
            S_WD: begin
                if (HREADY) begin
                    if (HRESP) begin
                        err_d   = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        cnt_d = cnt_q - LEN_W'(1);
                        src_d = src_q + 30'd1;
                        dst_d = dst_q + 30'd1;
                        if (cnt_q == LEN_W'(1)) state_d = S_FIN;
                        else if (fill_mode)     state_d = S_WA;
                        else                    state_d = S_RA;
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            zlen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
            zlen_q  <= zlen_d;
        end
    end

    // Bus outputs decode straight from registered state, so an async reset
    // drops them immediately and they are held while the state waits.
    always_comb begin
        HTRANS = 2'b00;
        HADDR  = '0;
        HWRITE = 1'b0;
        HWDATA = '0;
        case (state_q)
            S_RA: begin
                HTRANS = 2'b10;
                HADDR  = {src_q, 2'b00};
            end
            S_WA: begin
                HTRANS = 2'b10;
                HADDR  = {dst_q, 2'b00};
                HWRITE = 1'b1;
            end
            S_WD:    HWDATA = fill_mode ? wdata_fill : data_q;
            default: ;
        endcase
    end

    assign HBURST    = 3'b000;
    assign HMASTLOCK = 1'b0;
    assign HPROT     = 4'b0011;
    assign HSIZE     = 3'b010;

    assign done = (state_q == S_FIN);
    // busy drops as done rises, except a len=0 job which is busy only in FIN.
    assign busy = (state_q == S_RA) || (state_q == S_RD) || (state_q == S_WA) ||
                  (state_q == S_WD) || ((state_q == S_FIN) && zlen_q);
    assign err  = err_q;

endmodule

// File: tb/tb_mfp_ahb_copy_master.sv
module tb_mfp_ahb_copy_master;
    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0, dst_addr = '0;
    logic [15:0] len = '0;
    logic        fill = 1'b0;
    logic [31:0] fill_data = '0;
    logic        busy, done, err;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [2:0]  HBURST, HSIZE;
    logic        HMASTLOCK, HWRITE, HREADY, HRESP;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;

    int checks = 0, errors = 0;

    mfp_ahb_copy_master #(.LEN_W(16)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .src_addr(src_addr),
        .dst_addr(dst_addr), .len(len), .fill(fill), .fill_data(fill_data),
        .busy(busy), .done(done), .err(err), .HADDR(HADDR), .HBURST(HBURST),
        .HMASTLOCK(HMASTLOCK), .HPROT(HPROT), .HSIZE(HSIZE), .HTRANS(HTRANS),
        .HWDATA(HWDATA), .HWRITE(HWRITE), .HRDATA(HRDATA), .HREADY(HREADY),
        .HRESP(HRESP)
    );

    initial forever #5 HCLK = ~HCLK;

    int          cfg_wait = 0;
    int          cfg_err_rd = -1;
    int          rd_cnt = 0;
    int          dp_wait = 0;
    logic        dp_v = 1'b0, dp_w = 1'b0, dp_e = 1'b0;
    logic [31:0] dp_a = '0, dp_rd = '0;
    logic [31:0] tr_a[$];
    logic [31:0] wr_a[$];
    logic [31:0] wr_d[$];

    assign HREADY = !(dp_v && dp_wait != 0);
    assign HRESP  = dp_v && dp_wait == 0 && dp_e;
    assign HRDATA = dp_rd;

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_v    <= 1'b0;
            dp_e    <= 1'b0;
            dp_wait <= 0;
        end else if (dp_v && dp_wait > 0) begin
            dp_wait <= dp_wait - 1;
        end else begin
            if (dp_v && dp_w && !dp_e) begin
                wr_a.push_back(dp_a);
                wr_d.push_back(HWDATA);
            end
            if (HTRANS == 2'b10) begin
                dp_v    <= 1'b1;
                dp_a    <= HADDR;
                dp_w    <= HWRITE;
                dp_wait <= cfg_wait;
                tr_a.push_back(HADDR);
                if (!HWRITE) begin
                    rd_cnt <= rd_cnt + 1;
                    dp_e   <= (rd_cnt + 1 == cfg_err_rd);
                    dp_rd  <= ~HADDR;
                end else begin
                    dp_e <= 1'b0;
                end
            end else begin
                dp_v <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic pulse_start(input logic [31:0] s, input logic [31:0] d,
                               input logic [15:0] n, input logic f, input logic [31:0] fd);
        start = 1'b1; src_addr = s; dst_addr = d; len = n; fill = f; fill_data = fd;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int k);
        logic [31:0] pa, pd;
        logic [1:0]  pt;
        logic        pr;
        k = 0;
        while (done !== 1'b1 && k < 400) begin
            pa = HADDR; pd = HWDATA; pt = HTRANS; pr = HREADY;
            tick();
            k++;
            if (pr === 1'b0) begin
                chk("wait_haddr", HADDR, pa);
                chk("wait_hwdata", HWDATA, pd);
                chk("wait_htrans", HTRANS, pt);
            end
        end
        chk("done_seen", done, 1'b1);
    endtask

    logic [31:0] exp_a1 [6];
    int k, k2, tb0, wb0, rb0;

    initial begin
        exp_a1 = '{32'h1FC00010, 32'h00000100, 32'h1FC00014,
                   32'h00000104, 32'h1FC00018, 32'h00000108};

        repeat (2) tick();
        chk("rst_htrans", HTRANS, 2'b00);
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_hwrite", HWRITE, 1'b0);
        chk("rst_hwdata", HWDATA, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("hburst", HBURST, 3'b000);
        chk("hsize", HSIZE, 3'b010);
        chk("hprot", HPROT, 4'b0011);
        chk("hmastlock", HMASTLOCK, 1'b0);
        HRESETn = 1'b1;
        tick();

        tb0 = tr_a.size(); wb0 = wr_a.size();
        pulse_start(32'h1FC00012, 32'h00000101, 16'd3, 1'b0, 32'h0);
        chk("t1_busy_n1", busy, 1'b1);
        chk("t1_htrans_n1", HTRANS, 2'b10);
        chk("t1_haddr_n1", HADDR, 32'h1FC00010);
        wait_done(k);
        chk("t1_latency", k, 12);
        chk("t1_err", err, 1'b0);
        chk("t1_busy_at_done", busy, 1'b0);
        chk("t1_ntrans", tr_a.size() - tb0, 6);
        for (int i = 0; i < 6; i++) chk("t1_addr_seq", tr_a[tb0 + i], exp_a1[i]);
        chk("t1_wd0", wr_d[wb0],     32'hE03FFFEF);
        chk("t1_wd1", wr_d[wb0 + 1], 32'hE03FFFEB);
        chk("t1_wd2", wr_d[wb0 + 2], 32'hE03FFFE7);
        tick();
        chk("t1_done_pulse", done, 1'b0);

        cfg_wait = 2; wb0 = wr_a.size();
        pulse_start(32'h1FC00020, 32'h00000200, 16'd2, 1'b0, 32'h0);
        wait_done(k);
        chk("t2_latency", k, 16);
        chk("t2_nwr", wr_a.size() - wb0, 2);
        chk("t2_wa1", wr_a[wb0 + 1], 32'h00000204);
        chk("t2_wd0", wr_d[wb0],     32'hE03FFFDF);
        chk("t2_wd1", wr_d[wb0 + 1], 32'hE03FFFDB);
        cfg_wait = 0;
        tick();

        cfg_err_rd = rd_cnt + 2; wb0 = wr_a.size();
        pulse_start(32'h1FC00010, 32'h00000300, 16'd4, 1'b0, 32'h0);
        wait_done(k);
        chk("t3_latency", k, 6);
        chk("t3_err", err, 1'b1);
        chk("t3_nwr", wr_a.size() - wb0, 1);
        chk("t3_wa0", wr_a[wb0], 32'h00000300);
        chk("t3_wd0", wr_d[wb0], 32'hE03FFFEF);
        cfg_err_rd = -1;
        repeat (3) tick();
        chk("t3_err_sticky", err, 1'b1);
        chk("t3_idle_busy", busy, 1'b0);

        tb0 = tr_a.size();
        pulse_start(32'h1FC00010, 32'h00000800, 16'd0, 1'b0, 32'h0);
        chk("t4_done_n1", done, 1'b1);
        chk("t4_busy_n1", busy, 1'b1);
        chk("t4_err_clr", err, 1'b0);
        chk("t4_htrans", HTRANS, 2'b00);
        tick();
        chk("t4_done_off", done, 1'b0);
        chk("t4_busy_off", busy, 1'b0);
        chk("t4_no_trans", tr_a.size() - tb0, 0);

        wb0 = wr_a.size();
        pulse_start(32'h1FC00040, 32'h00000400, 16'd5, 1'b0, 32'h0);
        repeat (3) tick();
        pulse_start(32'h1FC00000, 32'h00000900, 16'd1, 1'b0, 32'h0);
        wait_done(k2);
        chk("t5_latency", k2 + 4, 20);
        chk("t5_nwr", wr_a.size() - wb0, 5);
        chk("t5_wa4", wr_a[wb0 + 4], 32'h00000410);
        chk("t5_wd4", wr_d[wb0 + 4], 32'hE03FFFAF);
        repeat (3) tick();
        chk("t5_no_restart", wr_a.size() - wb0, 5);
        chk("t5_idle", busy, 1'b0);

        wb0 = wr_a.size();
        pulse_start(32'h1FC00010, 32'h00000500, 16'd2, 1'b0, 32'h0);
        repeat (2) tick();
        chk("t6_in_wa", HWRITE, 1'b1);
        #2 HRESETn = 1'b0;
        #1;
        chk("t6_rst_htrans", HTRANS, 2'b00);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_haddr", HADDR, 32'h0);
        tick();
        HRESETn = 1'b1;
        repeat (2) tick();
        pulse_start(32'h1FC00018, 32'h00000600, 16'd1, 1'b0, 32'h0);
        wait_done(k);
        chk("t6_latency", k, 4);
        chk("t6_nwr", wr_a.size() - wb0, 1);
        chk("t6_wa", wr_a[wb0], 32'h00000600);
        chk("t6_wd", wr_d[wb0], 32'hE03FFFE7);
        tick();

`ifdef MFP_AHB_COPY_FILL_EN
        wb0 = wr_a.size(); rb0 = rd_cnt;
        pulse_start(32'h1FC00010, 32'hFFFFFFF8, 16'd4, 1'b1, 32'hDEADBEEF);
        wait_done(k);
        chk("t7_latency", k, 8);
        chk("t7_nrd", rd_cnt - rb0, 0);
        chk("t7_nwr", wr_a.size() - wb0, 4);
        chk("t7_wa0", wr_a[wb0],     32'hFFFFFFF8);
        chk("t7_wa1", wr_a[wb0 + 1], 32'hFFFFFFFC);
        chk("t7_wa2", wr_a[wb0 + 2], 32'h00000000);
        chk("t7_wa3", wr_a[wb0 + 3], 32'h00000004);
        chk("t7_wd3", wr_d[wb0 + 3], 32'hDEADBEEF);
`else
        wb0 = wr_a.size(); rb0 = rd_cnt;
        pulse_start(32'h1FC00010, 32'h00000700, 16'd1, 1'b1, 32'hDEADBEEF);
        wait_done(k);
        chk("t7_latency", k, 4);
        chk("t7_nrd", rd_cnt - rb0, 1);
        chk("t7_wa0", wr_a[wb0], 32'h00000700);
        chk("t7_wd0", wr_d[wb0], 32'hE03FFFEF);
`endif
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
